// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and scan-code decoder.
// Deserialises 11-bit PS/2 frames, tracks the E0 (extended) and F0 (break)
// prefixes, and produces a 9-bit key code, make/break strobes, a frame error
// strobe and level "pressed" flags for keypad 4/5/6.
module ps2_key_decoder #(
    parameter int          TIMEOUT_CYCLES = 50000,
    parameter logic [8:0]  KEY_LEFT_CODE  = 9'h06B,
    parameter logic [8:0]  KEY_MID_CODE   = 9'h073,
    parameter logic [8:0]  KEY_RIGHT_CODE = 9'h074
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [8:0] key_code,
    output logic       make,
    output logic       breakk,
    output logic       frame_err,
    output logic       key4_pressed,
    output logic       key5_pressed,
    output logic       key6_pressed
);

    localparam int             TW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state, state_next;
    logic          clk_s1, clk_s2, clk_prev;
    logic          dat_s1, dat_s2;
    logic          fall;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          par_bit;
    logic [TW-1:0] tcnt;
    logic          ext_pending, brk_pending;
    logic          timeout, frame_done, good_frame;
    logic [8:0]    code;

    assign fall       = clk_prev & ~clk_s2;
    assign good_frame = dat_s2 & (^shift_reg ^ par_bit);
    assign code       = {ext_pending, shift_reg};

    // Two-flop synchronisers for the raw PS/2 lines plus the edge-detect history.
    always_ff @(posedge clk) begin
        // NOTE: synchroniser flops reset to the idle-high line level so that
        // leaving reset can never fabricate a falling edge on ps2_clk.
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the old
            // value of its neighbour, which is what builds the shift chain.
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_dat;
            dat_s2   <= dat_s1;
        end
    end

    // Receive FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Receive FSM next-state logic; a timeout overrides any other transition.
    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latches).
        state_next = state;
        timeout    = 1'b0;
        frame_done = 1'b0;
        if (state != S_IDLE && !fall && tcnt == TLAST) begin
            timeout    = 1'b1;
            state_next = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:   if (fall && !dat_s2) state_next = S_START;
                S_START:  state_next = S_DATA;
                S_DATA:   if (fall && bit_cnt == 3'd7) state_next = S_PARITY;
                S_PARITY: if (fall) state_next = S_STOP;
                S_STOP: begin
                    if (fall) begin
                        frame_done = 1'b1;
                        state_next = S_IDLE;
                    end
                end
                default:  state_next = S_IDLE;
            endcase
        end
    end

    // Frame datapath, prefix tracking, strobes and pressed flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt      <= '0;
            shift_reg    <= '0;
            par_bit      <= 1'b0;
            tcnt         <= '0;
            ext_pending  <= 1'b0;
            brk_pending  <= 1'b0;
            key_code     <= '0;
            make         <= 1'b0;
            breakk       <= 1'b0;
            frame_err    <= 1'b0;
            key4_pressed <= 1'b0;
            key5_pressed <= 1'b0;
            key6_pressed <= 1'b0;
        end else begin
            make      <= 1'b0;
            breakk    <= 1'b0;
            frame_err <= 1'b0;

            if (state == S_IDLE || fall || timeout) tcnt <= '0;
            else                                    tcnt <= tcnt + 1'b1;

            if (state == S_START) bit_cnt <= '0;
            if (state == S_DATA && fall) begin
                shift_reg <= {dat_s2, shift_reg[7:1]};
                bit_cnt   <= bit_cnt + 3'd1;
            end
            if (state == S_PARITY && fall) par_bit <= dat_s2;

            if (timeout) frame_err <= 1'b1;

            if (frame_done) begin
                if (!good_frame) begin
                    frame_err   <= 1'b1;
                    ext_pending <= 1'b0;
                    brk_pending <= 1'b0;
                end else if (shift_reg == 8'hE0) begin
                    ext_pending <= 1'b1;
                end else if (shift_reg == 8'hF0) begin
                    brk_pending <= 1'b1;
                end else begin
                    key_code    <= code;
                    ext_pending <= 1'b0;
                    brk_pending <= 1'b0;
                    if (brk_pending) begin
                        breakk <= 1'b1;
                        if (code == KEY_LEFT_CODE)  key4_pressed <= 1'b0;
                        if (code == KEY_MID_CODE)   key5_pressed <= 1'b0;
                        if (code == KEY_RIGHT_CODE) key6_pressed <= 1'b0;
                    end else begin
                        make <= 1'b1;
                        if (code == KEY_LEFT_CODE)  key4_pressed <= 1'b1;
                        if (code == KEY_MID_CODE)   key5_pressed <= 1'b1;
                        if (code == KEY_RIGHT_CODE) key6_pressed <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios with literal
// expectations plus randomized frames, all compared every cycle against a
// frame-level behavioural model.
module tb_ps2_key_decoder;

    localparam int T = 300;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [8:0] key_code;
    logic       make, breakk, frame_err;
    logic       key4_pressed, key5_pressed, key6_pressed;

    int errors = 0;
    int checks = 0;
    int half = 8;
    bit cmp_en = 1'b0;
    int make_n = 0, brk_n = 0, err_n = 0;
    int s_make, s_brk, s_err;

    ps2_key_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_dat      (ps2_dat),
        .key_code     (key_code),
        .make         (make),
        .breakk       (breakk),
        .frame_err    (frame_err),
        .key4_pressed (key4_pressed),
        .key5_pressed (key5_pressed),
        .key6_pressed (key6_pressed)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [8:0] e_code;
    bit e_make, e_brk, e_err, e4, e5, e6;
    bit ext_p, brk_p;
    bit c1, c2, c3, d1, d2;
    bit q[$];
    int m_cyc = 0;
    int last_fall = 0;

    task automatic finish_frame();
        logic [7:0] data;
        logic [8:0] kc;
        bit good;
        for (int i = 0; i < 8; i++) data[i] = q[i+1];
        good = q[10] && ((^data) ^ q[9]);
        if (!good) begin
            e_err = 1; ext_p = 0; brk_p = 0;
        end else if (data == 8'hE0) ext_p = 1;
        else if (data == 8'hF0) brk_p = 1;
        else begin
            kc = {ext_p, data};
            e_code = kc;
            if (brk_p) begin
                e_brk = 1;
                if (kc == 9'h06B) e4 = 0;
                if (kc == 9'h073) e5 = 0;
                if (kc == 9'h074) e6 = 0;
            end else begin
                e_make = 1;
                if (kc == 9'h06B) e4 = 1;
                if (kc == 9'h073) e5 = 1;
                if (kc == 9'h074) e6 = 1;
            end
            ext_p = 0; brk_p = 0;
        end
    endtask

    // The synchronised view of a PS/2 line lags the pins by two samples; a
    // falling edge is acted on one cycle after it appears in that view.
    initial begin
        bit fall, b;
        forever begin
            @(posedge clk);
            m_cyc++;
            e_make = 0; e_brk = 0; e_err = 0;
            if (reset) begin
                e_code = '0; e4 = 0; e5 = 0; e6 = 0; ext_p = 0; brk_p = 0;
                c1 = 1; c2 = 1; c3 = 1; d1 = 1; d2 = 1;
                q.delete();
            end else begin
                fall = c3 && !c2;
                b    = d2;
                if (fall) begin
                    last_fall = m_cyc;
                    if (q.size() == 0) begin
                        if (!b) q.push_back(b);
                    end else begin
                        q.push_back(b);
                        if (q.size() == 11) begin
                            finish_frame();
                            q.delete();
                        end
                    end
                end else if (q.size() != 0 && m_cyc - last_fall == T) begin
                    e_err = 1;
                    q.delete();
                end
                c3 = c2; c2 = c1; c1 = ps2_clk;
                d2 = d1; d1 = ps2_dat;
            end
        end
    end

    // Per-cycle comparison against the model, plus strobe counters.
    initial begin
        forever begin
            @(negedge clk);
            if (make === 1'b1)      make_n++;
            if (breakk === 1'b1)    brk_n++;
            if (frame_err === 1'b1) err_n++;
            if (cmp_en)
                check("cycle_outputs",
                      {17'd0, key_code, make, breakk, frame_err, key4_pressed, key5_pressed, key6_pressed},
                      {17'd0, e_code, e_make, e_brk, e_err, e4, e5, e6});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit b);
        ps2_dat = b;
        tick(half);
        ps2_clk = 1'b0;
        tick(half);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input bit par_bad, input bit stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit((~^data) ^ par_bad);
        send_bit(stop);
        ps2_dat = 1'b1;
        tick(2 * half);
    endtask

    task automatic good_frame(input logic [7:0] data);
        send_frame(data, 1'b0, 1'b1);
    endtask

    task automatic snap();
        s_make = make_n; s_brk = brk_n; s_err = err_n;
    endtask

    task automatic expect_ev(input string nm, input int dm, input int db, input int de);
        check({nm, "_make_cycles"},  make_n - s_make, dm);
        check({nm, "_break_cycles"}, brk_n - s_brk,   db);
        check({nm, "_err_cycles"},   err_n - s_err,   de);
    endtask

    initial begin
        logic [7:0] pick [6];
        logic [7:0] data;
        int k;
        pick[0] = 8'hE0; pick[1] = 8'hF0; pick[2] = 8'h6B;
        pick[3] = 8'h73; pick[4] = 8'h74; pick[5] = 8'h00;

        tick(3);
        cmp_en = 1'b1;
        check("reset_state", {key_code, make, breakk, frame_err, key4_pressed, key5_pressed, key6_pressed}, 0);
        reset = 1'b0;
        tick(10);

        // 1: plain make of keypad 4
        snap(); good_frame(8'h6B);
        expect_ev("t1", 1, 0, 0);
        check("t1_code", key_code, 9'h06B);
        check("t1_key4", key4_pressed, 1);

        // 2: F0 alone produces nothing, then release of keypad 4
        snap(); good_frame(8'hF0);
        expect_ev("t2_prefix", 0, 0, 0);
        check("t2_code_held", key_code, 9'h06B);
        snap(); good_frame(8'h6B);
        expect_ev("t2", 0, 1, 0);
        check("t2_key4", key4_pressed, 0);

        // 3: extended codes do not alias keypad 4
        snap(); good_frame(8'hE0); good_frame(8'h6B);
        expect_ev("t3_make", 1, 0, 0);
        check("t3_code", key_code, 9'h16B);
        check("t3_key4", key4_pressed, 0);
        snap(); good_frame(8'hE0); good_frame(8'hF0); good_frame(8'h6B);
        expect_ev("t3_break", 0, 1, 0);
        check("t3_break_code", key_code, 9'h16B);

        // 4: bad parity, then a good frame
        snap(); send_frame(8'h73, 1'b1, 1'b1);
        expect_ev("t4_bad", 0, 0, 1);
        check("t4_code_held", key_code, 9'h16B);
        check("t4_key5", key5_pressed, 0);
        snap(); good_frame(8'h73);
        expect_ev("t4_good", 1, 0, 0);
        check("t4_key5_set", key5_pressed, 1);

        // 5: truncated frame times out
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        tick(T + 10);
        expect_ev("t5_timeout", 0, 0, 1);
        snap(); good_frame(8'h74);
        expect_ev("t5_next", 1, 0, 0);
        check("t5_key6", key6_pressed, 1);

        // 6: reset mid-frame, recovery, and a bad stop bit
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        reset = 1'b1;
        tick(1);
        check("t6_reset_outputs", {key_code, make, breakk, frame_err, key4_pressed, key5_pressed, key6_pressed}, 0);
        reset = 1'b0;
        tick(20);
        snap(); good_frame(8'h74);
        expect_ev("t6_next", 1, 0, 0);
        check("t6_key6", key6_pressed, 1);
        snap(); send_frame(8'h11, 1'b0, 1'b0);
        expect_ev("t6_stop0", 0, 0, 1);

        // Randomized traffic against the model
        for (int n = 0; n < 120; n++) begin
            half = $urandom_range(4, 10);
            data = pick[$urandom_range(0, 5)];
            if (data == 8'h00) data = 8'($urandom);
            if ($urandom_range(0, 24) == 0) begin
                k = $urandom_range(0, 9);
                send_bit(1'b0);
                for (int i = 0; i < k; i++) send_bit(1'($urandom));
                ps2_dat = 1'b1;
                tick(T + 10);
            end else begin
                send_frame(data, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) != 0));
            end
            tick($urandom_range(2, 20));
        end

        tick(20);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
